// File: rtl/store_narrow_pkg.sv
// store_narrow_pkg
//   Shared definitions for the store-path byte narrower and its helpers:
//   store size encodings, FSM state encoding, and the size-to-byte-count
//   and alignment helpers.
package store_narrow_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Number of bytes written for a store size. The reserved encoding is
    // treated as a full word so the block never stalls on a bad size.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        logic [2:0] cnt;
        case (size)
            SIZE_BYTE: cnt = 3'd1;
            SIZE_HALF: cnt = 3'd2;
            default:   cnt = 3'd4;
        endcase
        return cnt;
    endfunction

    // True for a half at an odd address, a word not on a 4-byte boundary,
    // or the reserved size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_narrow_byte_lane_sel.sv
// byte_lane_sel
//   Combinational byte selector, shared with the load path.
//   Ports:
//     data [31:0] : little-endian source word
//     idx  [1:0]  : byte lane (0 = bits 7:0)
//     lane [7:0]  : selected byte
module byte_lane_sel (
    input  logic [31:0] data,
    input  logic [1:0]  idx,
    output logic [7:0]  lane
);

    always_comb begin
        lane = 8'h00;
        case (idx)
            2'd0: lane = data[7:0];
            2'd1: lane = data[15:8];
            2'd2: lane = data[23:16];
            2'd3: lane = data[31:24];
            default: lane = 8'h00;
        endcase
    end

endmodule

// File: rtl/store_narrow.sv
// store_narrow
//   Writes the low 1, 2 or 4 bytes of a 32-bit register value to a byte-wide
//   data memory, one byte per accepted beat, little-endian, and pulses done_o
//   when finished so the control unit can release its stall.
//
//   Optional feature macro: STORE_NARROW_MISALIGN_TRAP_EN
//     defined   : misaligned / reserved-size requests skip all memory beats
//                 and finish with done_o and err_o high together.
//     undefined : err_o is tied low; misaligned stores are written
//                 byte-serially at consecutive addresses.
//
//   Ports:
//     clk_i, rst_i (async, active-low)
//     req_valid_i, req_ready_o, req_size_i, req_addr_i, req_data_i : request
//     mem_we_o, mem_addr_o, mem_data_o, mem_ack_i                  : memory beat
//     done_o, err_o                                                : completion
//     state_o                                                      : FSM state (debug)
//
//   Handshakes: a request transfers on a rising edge where req_valid_i and
//   req_ready_o are both high; the requester holds the request until then.
//   A memory beat transfers on a rising edge where mem_we_o and mem_ack_i are
//   both high; without ack every mem_* output holds.
module store_narrow
    import store_narrow_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_data_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    input  logic              mem_ack_i,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        state_o
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [1:0]        idx_q;
    logic [1:0]        last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              accept;
    logic              trap;
    logic [1:0]        req_last;

    assign accept   = req_valid_i & ready_q;
    assign req_last = 2'(size_to_count(req_size_i) - 3'd1);

`ifdef STORE_NARROW_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = trap ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack_i && (idx_q == last_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Registered ready: low through reset, high one edge after release
        // and in every IDLE cycle thereafter.
        ready_d = (state_d == ST_IDLE);
    end

    // Beat address is kept as its own counter so mem_addr_o is a plain
    // register output; it wraps naturally at the top of the address space.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q  <= 2'd0;
            last_q <= 2'd0;
            addr_q <= '0;
            data_q <= 32'h0;
        end else if (accept) begin
            idx_q  <= 2'd0;
            last_q <= req_last;
            addr_q <= req_addr_i;
            data_q <= req_data_i;
        end else if ((state_q == ST_WRITE) && mem_ack_i && (idx_q != last_q)) begin
            idx_q  <= idx_q + 2'd1;
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

`ifdef STORE_NARROW_MISALIGN_TRAP_EN
    logic err_q;
    // A trapped accept always lands in DONE next cycle, so this flag is
    // high exactly alongside that done_o pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & trap;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    byte_lane_sel u_lane (
        .data (data_q),
        .idx  (idx_q),
        .lane (mem_data_o)
    );

    assign req_ready_o = ready_q;
    assign mem_we_o    = (state_q == ST_WRITE);
    assign mem_addr_o  = addr_q;
    assign done_o      = (state_q == ST_DONE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_store_narrow.sv
module tb_store_narrow;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_ack_i;
    logic        done_o;
    logic        err_o;
    logic [1:0]  state_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [39:0] exp_q[$];      // {addr, byte} per expected beat
    logic        exp_err_q[$];  // err_o per expected done pulse

    store_narrow #(.ADDR_W(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_size_i  (req_size_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_ack_i   (mem_ack_i),
        .done_o      (done_o),
        .err_o       (err_o),
        .state_o     (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_i) begin
            if (mem_we_o && mem_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {mem_addr_o, mem_data_o}, 40'h0);
                end else begin
                    check("beat", {mem_addr_o, mem_data_o}, exp_q.pop_front());
                end
            end
            if (done_o) begin
                done_cyc = cyc;
                done_cnt++;
                if (exp_err_q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    check("done_err", err_o, exp_err_q.pop_front());
                end
            end else begin
                check("err_without_done", err_o, 1'b0);
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one request; stall = cycles of ack low on beat 0; done_off is
    // the cycle of done_o counted from the accept edge N (done at N+done_off).
    task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input int stall,
                            input int done_off, input logic [7:0] b0);
        int acc;
        int t;
        int d0;
        @(negedge clk);
        req_size_i  = size;
        req_addr_i  = addr;
        req_data_i  = data;
        req_valid_i = 1'b1;
        mem_ack_i   = (stall == 0);
        t = 0;
        while (req_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            check("ready_timeout", 1'b0, 1'b1);
            req_valid_i = 1'b0;
            return;
        end
        acc = cyc + 1;
        d0 = done_cnt;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_we", mem_we_o, 1'b1);
            check("stall_addr", mem_addr_o, addr);
            check("stall_data", mem_data_o, b0);
        end
        if (stall > 0) begin
            @(posedge clk);
            #1 mem_ack_i = 1'b1;
        end
        t = 0;
        while (done_cnt == d0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            check("done_timeout", 1'b0, 1'b1);
        end else begin
            check("done_latency", done_cyc - acc, done_off - 1);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int t;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_size_i  = 2'b00;
        req_addr_i  = 32'h0;
        req_data_i  = 32'h0;
        mem_ack_i   = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_ready", req_ready_o, 1'b0);
        check("rst_outs", {mem_we_o, mem_addr_o, mem_data_o, done_o, err_o}, 43'h0);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 check("ready_after_rst", req_ready_o, 1'b1);

        // Byte store
        exp_q.push_back({32'h0000_0100, 8'hEF});
        exp_err_q.push_back(1'b0);
        do_store(2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 0, 2, 8'hEF);

        // Word store
        exp_q.push_back({32'h0000_0200, 8'h44});
        exp_q.push_back({32'h0000_0201, 8'h33});
        exp_q.push_back({32'h0000_0202, 8'h22});
        exp_q.push_back({32'h0000_0203, 8'h11});
        exp_err_q.push_back(1'b0);
        do_store(2'b10, 32'h0000_0200, 32'h1122_3344, 0, 5, 8'h44);

        // Backpressure on beat 0 of a half store
        exp_q.push_back({32'h0000_0010, 8'hCD});
        exp_q.push_back({32'h0000_0011, 8'hAB});
        exp_err_q.push_back(1'b0);
        do_store(2'b01, 32'h0000_0010, 32'h0000_ABCD, 3, 6, 8'hCD);

        // Address wrap
        exp_q.push_back({32'hFFFF_FFFE, 8'hD4});
        exp_q.push_back({32'hFFFF_FFFF, 8'hC3});
        exp_q.push_back({32'h0000_0000, 8'hB2});
        exp_q.push_back({32'h0000_0001, 8'hA1});
        exp_err_q.push_back(1'b0);
        do_store(2'b10, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 0, 5, 8'hD4);

        // Misaligned half
`ifdef STORE_NARROW_MISALIGN_TRAP_EN
        exp_err_q.push_back(1'b1);
        do_store(2'b01, 32'h0000_0101, 32'h0000_1234, 0, 1, 8'h34);
        // Reserved size traps too
        exp_err_q.push_back(1'b1);
        do_store(2'b11, 32'h0000_0400, 32'h0000_5678, 0, 1, 8'h78);
`else
        exp_q.push_back({32'h0000_0101, 8'h34});
        exp_q.push_back({32'h0000_0102, 8'h12});
        exp_err_q.push_back(1'b0);
        do_store(2'b01, 32'h0000_0101, 32'h0000_1234, 0, 3, 8'h34);
`endif

        // Back-to-back byte store right after a completion
        exp_q.push_back({32'h0000_0055, 8'h5A});
        exp_err_q.push_back(1'b0);
        do_store(2'b00, 32'h0000_0055, 32'hFFFF_FF5A, 0, 2, 8'h5A);

        // Reset mid word store: only beats 0 and 1 are seen, no done
        exp_q.push_back({32'h0000_0300, 8'h88});
        exp_q.push_back({32'h0000_0301, 8'h77});
        @(negedge clk);
        req_size_i  = 2'b10;
        req_addr_i  = 32'h0000_0300;
        req_data_i  = 32'h5566_7788;
        req_valid_i = 1'b1;
        mem_ack_i   = 1'b1;
        t = 0;
        while (req_ready_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("mid_rst_ready", req_ready_o, 1'b1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_i = 1'b0;
        #1 check("mid_rst_outs", {mem_we_o, mem_addr_o, mem_data_o, done_o, err_o}, 43'h0);
        check("mid_rst_ready_low", req_ready_o, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1 check("mid_rst_ready_after", req_ready_o, 1'b1);
        check("mid_rst_state", state_o, 2'd0);
        repeat (5) @(negedge clk);

        check("beats_left", exp_q.size(), 0);
        check("dones_left", exp_err_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
